// File: rtl/cdc_reg_bridge.sv
// ============================================================================
// cdc_reg_bridge
// ----------------------------------------------------------------------------
// Purpose:
//   ASCII register-access bridge placed between the USB CDC receive and send
//   ports. Hex text commands from the host terminal are buffered in a small
//   input FIFO and parsed one byte per cycle. They are executed as single-byte
//   reads or writes on a simple local register bus. A short text response is
//   then returned through the CDC send handshake.
//
//   Commands : wAADD<term>  write data DD to address AA   -> "K" CR LF
//              rAA<term>    read address AA               -> "HH" CR LF
//              anything malformed                         -> "E" CR LF
//              <term> is CR or LF; a bare terminator in IDLE is ignored.
//
// Ports:
//   clk         system clock (shared with the CDC core)
//   rstn        asynchronous active-low reset, clears all state
//   recv_data   received byte from the CDC core
//   recv_valid  one-cycle strobe qualifying recv_data (no backpressure)
//   send_data   response byte to the CDC send port
//   send_valid  response byte valid
//   send_ready  CDC send buffer accepts the byte this cycle
//   reg_addr    register address
//   reg_wdata   register write data
//   reg_wr      one-cycle write strobe
//   reg_rd      one-cycle read strobe
//   reg_rdata   read data, sampled one cycle after reg_rd
//   ovf         sticky input-overflow flag, cleared when the error reply is
//               issued
//
// Parameters:
//   IFIFO_ASIZE log2 depth of the input byte FIFO
// ============================================================================
`timescale 1ns/1ps

module cdc_reg_bridge #(
    parameter int IFIFO_ASIZE = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] recv_data,
    input  logic       recv_valid,
    output logic [7:0] send_data,
    output logic       send_valid,
    input  logic       send_ready,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    output logic       ovf
);

    localparam int FIFO_DEPTH = 1 << IFIFO_ASIZE;
    localparam logic [IFIFO_ASIZE:0] PTR_ONE = 1;

    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_K  = 8'h4B;
    localparam logic [7:0] CH_E  = 8'h45;
    localparam logic [7:0] CH_W  = 8'h77;
    localparam logic [7:0] CH_UW = 8'h57;
    localparam logic [7:0] CH_R  = 8'h72;
    localparam logic [7:0] CH_UR = 8'h52;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_TERM,
        ST_DISCARD,
        ST_EXEC,
        ST_RDWAIT,
        ST_ERR,
        ST_RESP
    } state_t;

    // ------------------------------------------------------------------------
    // Character helpers
    // ------------------------------------------------------------------------
    function automatic logic is_term(input logic [7:0] c);
        return (c == CH_CR) || (c == CH_LF);
    endfunction

    function automatic logic is_hex(input logic [7:0] c);
        return ((c >= 8'h30) && (c <= 8'h39)) ||
               ((c >= 8'h41) && (c <= 8'h46)) ||
               ((c >= 8'h61) && (c <= 8'h66));
    endfunction

    // Letters in either case share the low nibble 1..6, so adding 9 maps
    // them onto 10..15 without distinguishing upper and lower case.
    function automatic logic [3:0] hex_val(input logic [7:0] c);
        if (c <= 8'h39) begin
            return c[3:0];
        end
        return c[3:0] + 4'd9;
    endfunction

    // Responses always use uppercase hex digits.
    function automatic logic [7:0] to_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return {4'h3, n};
        end
        return {4'h4, n - 4'd9};
    endfunction

    // ------------------------------------------------------------------------
    // Input FIFO storage and pointers. Pointers carry one extra wrap bit so
    // that full and empty can be told apart without a separate counter.
    // ------------------------------------------------------------------------
    logic [7:0]             fifo_mem [FIFO_DEPTH];
    logic [IFIFO_ASIZE:0]   wr_ptr_q, wr_ptr_d;
    logic [IFIFO_ASIZE:0]   rd_ptr_q, rd_ptr_d;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic [7:0]             fifo_rd_data;
    logic                   push;
    logic                   pop;
    logic                   drop;

    assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
    assign fifo_full    = (wr_ptr_q[IFIFO_ASIZE] != rd_ptr_q[IFIFO_ASIZE]) &&
                          (wr_ptr_q[IFIFO_ASIZE-1:0] == rd_ptr_q[IFIFO_ASIZE-1:0]);
    assign fifo_rd_data = fifo_mem[rd_ptr_q[IFIFO_ASIZE-1:0]];

    // A pop in the same cycle frees a slot, so a push onto a full FIFO is
    // only dropped when the parser is not consuming at the same time.
    assign push = recv_valid && (!fifo_full || pop);
    assign drop = recv_valid && fifo_full && !pop;

    // ------------------------------------------------------------------------
    // Parser / response state
    // ------------------------------------------------------------------------
    state_t       state_q, state_d;
    logic         is_write_q, is_write_d;
    logic         nib_q, nib_d;
    logic [7:0]   addr_q, addr_d;
    logic [7:0]   wdata_q, wdata_d;
    logic         wr_q, wr_d;
    logic         rd_q, rd_d;
    logic         ovf_q, ovf_d;
    logic         send_valid_q, send_valid_d;
    logic [7:0]   send_data_q, send_data_d;
    logic [23:0]  resp_buf_q, resp_buf_d;
    logic [1:0]   resp_left_q, resp_left_d;

    // The FIFO memory holds no control state, so it is left out of reset;
    // flushing on reset is done by clearing the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[IFIFO_ASIZE-1:0]] <= recv_data;
        end
    end

    // Next-state logic. The first response byte goes straight into
    // send_data; the remaining bytes wait in resp_buf, oldest in the top
    // byte, and resp_left counts how many are still queued behind it.
    always_comb begin
        state_d      = state_q;
        is_write_d   = is_write_q;
        nib_d        = nib_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wr_d         = 1'b0;
        rd_d         = 1'b0;
        ovf_d        = ovf_q;
        send_valid_d = send_valid_q;
        send_data_d  = send_data_q;
        resp_buf_d   = resp_buf_q;
        resp_left_d  = resp_left_q;
        pop          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop   = 1'b1;
                    nib_d = 1'b0;
                    if ((fifo_rd_data == CH_W) || (fifo_rd_data == CH_UW)) begin
                        is_write_d = 1'b1;
                        state_d    = ST_ADDR;
                    end else if ((fifo_rd_data == CH_R) || (fifo_rd_data == CH_UR)) begin
                        is_write_d = 1'b0;
                        state_d    = ST_ADDR;
                    end else if (!is_term(fifo_rd_data)) begin
                        state_d    = ST_DISCARD;
                    end
                end
            end

            ST_ADDR: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (is_hex(fifo_rd_data)) begin
                        if (!nib_q) begin
                            addr_d[7:4] = hex_val(fifo_rd_data);
                            nib_d       = 1'b1;
                        end else begin
                            addr_d[3:0] = hex_val(fifo_rd_data);
                            nib_d       = 1'b0;
                            state_d     = is_write_q ? ST_DATA : ST_TERM;
                        end
                    end else if (is_term(fifo_rd_data)) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end
            end

            ST_DATA: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (is_hex(fifo_rd_data)) begin
                        if (!nib_q) begin
                            wdata_d[7:4] = hex_val(fifo_rd_data);
                            nib_d        = 1'b1;
                        end else begin
                            wdata_d[3:0] = hex_val(fifo_rd_data);
                            nib_d        = 1'b0;
                            state_d      = ST_TERM;
                        end
                    end else if (is_term(fifo_rd_data)) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end
            end

            // A command whose bytes may have been dropped by an overflow is
            // never executed; it is answered with an error instead.
            ST_TERM: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (is_term(fifo_rd_data)) begin
                        if (ovf_q) begin
                            state_d = ST_ERR;
                        end else begin
                            state_d = ST_EXEC;
                            wr_d    = is_write_q;
                            rd_d    = !is_write_q;
                        end
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end
            end

            ST_DISCARD: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (is_term(fifo_rd_data)) begin
                        state_d = ST_ERR;
                    end
                end
            end

            // The strobe is already on the bus during this state.
            ST_EXEC: begin
                if (is_write_q) begin
                    send_valid_d = 1'b1;
                    send_data_d  = CH_K;
                    resp_buf_d   = {CH_CR, CH_LF, 8'h00};
                    resp_left_d  = 2'd2;
                    state_d      = ST_RESP;
                end else begin
                    state_d      = ST_RDWAIT;
                end
            end

            ST_RDWAIT: begin
                send_valid_d = 1'b1;
                send_data_d  = to_ascii(reg_rdata[7:4]);
                resp_buf_d   = {to_ascii(reg_rdata[3:0]), CH_CR, CH_LF};
                resp_left_d  = 2'd3;
                state_d      = ST_RESP;
            end

            ST_ERR: begin
                send_valid_d = 1'b1;
                send_data_d  = CH_E;
                resp_buf_d   = {CH_CR, CH_LF, 8'h00};
                resp_left_d  = 2'd2;
                ovf_d        = 1'b0;
                state_d      = ST_RESP;
            end

            ST_RESP: begin
                if (send_ready) begin
                    if (resp_left_q == 2'd0) begin
                        send_valid_d = 1'b0;
                        state_d      = ST_IDLE;
                    end else begin
                        send_data_d  = resp_buf_q[23:16];
                        resp_buf_d   = {resp_buf_q[15:0], 8'h00};
                        resp_left_d  = resp_left_q - 2'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A fresh overflow outranks the clear in ST_ERR so it is not lost.
        if (drop) begin
            ovf_d = 1'b1;
        end

        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            is_write_q   <= 1'b0;
            nib_q        <= 1'b0;
            addr_q       <= 8'h00;
            wdata_q      <= 8'h00;
            wr_q         <= 1'b0;
            rd_q         <= 1'b0;
            ovf_q        <= 1'b0;
            send_valid_q <= 1'b0;
            send_data_q  <= 8'h00;
            resp_buf_q   <= 24'h000000;
            resp_left_q  <= 2'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            is_write_q   <= is_write_d;
            nib_q        <= nib_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            ovf_q        <= ovf_d;
            send_valid_q <= send_valid_d;
            send_data_q  <= send_data_d;
            resp_buf_q   <= resp_buf_d;
            resp_left_q  <= resp_left_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    assign send_data  = send_data_q;
    assign send_valid = send_valid_q;
    assign reg_addr   = addr_q;
    assign reg_wdata  = wdata_q;
    assign reg_wr     = wr_q;
    assign reg_rd     = rd_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_cdc_reg_bridge.sv
// ============================================================================
// tb_cdc_reg_bridge
// ----------------------------------------------------------------------------
// Directed bench for cdc_reg_bridge. Commands are typed in as text, response
// bytes transferred on the send handshake are collected in a queue, and
// register strobes are counted. Every expected value is a hand-computed
// constant.
// ============================================================================
`timescale 1ns/1ps

module tb_cdc_reg_bridge;

   logic       clk = 1'b0;
   logic       rstn;
   logic [7:0] recv_data;
   logic       recv_valid;
   logic [7:0] send_data;
   logic       send_valid;
   logic       send_ready;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_wr;
   logic       reg_rd;
   logic [7:0] reg_rdata;
   logic       ovf;

   int total = 0;
   int bad   = 0;

   logic [7:0] rxQ[$];
   int         wrCount   = 0;
   int         rdCount   = 0;
   int         bothCount = 0;
   logic [7:0] lastWrAddr = 8'h00;
   logic [7:0] lastWrData = 8'h00;
   logic [7:0] lastRdAddr = 8'h00;
   logic [7:0] rdValue    = 8'h00;

   // 100 MHz is fine for simulation; only cycle relationships matter.
   always #5 clk = ~clk;

   cdc_reg_bridge #(.IFIFO_ASIZE(4)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .recv_data  (recv_data),
      .recv_valid (recv_valid),
      .send_data  (send_data),
      .send_valid (send_valid),
      .send_ready (send_ready),
      .reg_addr   (reg_addr),
      .reg_wdata  (reg_wdata),
      .reg_wr     (reg_wr),
      .reg_rd     (reg_rd),
      .reg_rdata  (reg_rdata),
      .ovf        (ovf)
   );

   // Record transferred bytes and bus strobes mid-cycle, when everything
   // that the next rising edge will act on is already settled.
   always @(negedge clk) begin
      if (rstn === 1'b1) begin
         if (send_valid === 1'b1 && send_ready === 1'b1) rxQ.push_back(send_data);
         if (reg_wr === 1'b1) begin
            wrCount++;
            lastWrAddr = reg_addr;
            lastWrData = reg_wdata;
         end
         if (reg_rd === 1'b1) begin
            rdCount++;
            lastRdAddr = reg_addr;
         end
         if (reg_wr === 1'b1 && reg_rd === 1'b1) bothCount++;
      end
   end

   // Register model: read data is valid only in the cycle after the read
   // strobe and is garbage otherwise.
   initial begin
      reg_rdata = 8'hFF;
      forever begin
         @(negedge clk);
         if (reg_rd === 1'b1) begin
            @(posedge clk);
            #1 reg_rdata = rdValue;
            @(posedge clk);
            #1 reg_rdata = 8'hFF;
         end
      end
   end

   // Absolute time limit so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      recv_data  = b;
      recv_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idleInput();
      recv_valid = 1'b0;
      recv_data  = 8'h00;
   endtask

   task automatic sendCmd(input string s, input logic [7:0] term);
      for (int i = 0; i < s.len(); i++) applyStimulus(s[i]);
      applyStimulus(term);
      idleInput();
   endtask

   // Waits for n response bytes, then compares and removes them from the
   // front of the queue. exp holds the bytes right-aligned, first byte
   // most significant.
   task automatic expectBytes(input string tag, input logic [31:0] exp, input int n);
      int         cnt = 0;
      logic [31:0] got;
      while (rxQ.size() < n && cnt < 400) begin
         @(posedge clk);
         #2;
         cnt++;
      end
      checkOutput({tag, "_arrived"}, (rxQ.size() >= n) ? 32'd1 : 32'd0, 32'd1);
      for (int i = 0; i < n; i++) begin
         if (rxQ.size() > 0) got = {24'h0, rxQ.pop_front()};
         else                got = 32'hFFFF_FFFF;
         checkOutput($sformatf("%s_byte%0d", tag, i), got, {24'h0, exp[8*(n-1-i) +: 8]});
      end
   endtask

   task automatic expectQuiet(input string tag, input int cycles);
      repeat (cycles) @(posedge clk);
      #2;
      checkOutput(tag, rxQ.size(), 0);
   endtask

   task automatic waitValid(input string tag);
      int cnt = 0;
      while (send_valid !== 1'b1 && cnt < 100) begin
         @(posedge clk);
         #2;
         cnt++;
      end
      checkOutput(tag, {31'h0, send_valid}, 32'd1);
   endtask

   initial begin
      int unstable;
      int rdBefore;
      logic [7:0] held;
      string cmd;

      rstn       = 1'b0;
      recv_valid = 1'b0;
      recv_data  = 8'h00;
      send_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_outputs",
                  {4'h0, send_valid, reg_wr, reg_rd, ovf, send_data, reg_addr, reg_wdata},
                  32'h0);
      rstn = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Write command and a trailing stray LF
      sendCmd("w3CA5", 8'h0D);
      expectBytes("wr_resp", 32'h004B0D0A, 3);
      checkOutput("wr_count", wrCount, 1);
      checkOutput("wr_rd_count", rdCount, 0);
      checkOutput("wr_addr", {24'h0, lastWrAddr}, 32'h3C);
      checkOutput("wr_data", {24'h0, lastWrData}, 32'hA5);
      checkOutput("wr_addr_hold", {24'h0, reg_addr}, 32'h3C);
      sendCmd("", 8'h0A);
      expectQuiet("lf_idle_quiet", 20);

      // Read command with lowercase hex
      rdValue = 8'h5E;
      sendCmd("r3c", 8'h0A);
      expectBytes("rd_resp", 32'h35450D0A, 4);
      checkOutput("rd_count", rdCount, 1);
      checkOutput("rd_addr", {24'h0, lastRdAddr}, 32'h3C);
      checkOutput("rd_wr_count", wrCount, 1);

      // Malformed commands
      sendCmd("rG1", 8'h0A);
      expectBytes("bad_hex", 32'h00450D0A, 3);
      sendCmd("x12", 8'h0D);
      expectBytes("bad_cmd", 32'h00450D0A, 3);
      sendCmd("w12", 8'h0D);
      expectBytes("bad_short", 32'h00450D0A, 3);
      checkOutput("bad_wr_count", wrCount, 1);
      checkOutput("bad_rd_count", rdCount, 1);

      // Backpressure: stall the response for 100 cycles
      send_ready = 1'b0;
      rdValue    = 8'hB7;
      sendCmd("r00", 8'h0A);
      waitValid("bp_valid");
      held = send_data;
      checkOutput("bp_first", {24'h0, held}, 32'h42);
      unstable = 0;
      repeat (100) begin
         @(posedge clk);
         #2;
         if (send_valid !== 1'b1 || send_data !== held) unstable++;
      end
      checkOutput("bp_stable", unstable, 0);
      checkOutput("bp_none_sent", rxQ.size(), 0);
      send_ready = 1'b1;
      expectBytes("bp_resp", 32'h42370D0A, 4);
      expectQuiet("bp_no_dup", 20);
      checkOutput("bp_rd_count", rdCount, 2);

      // Overflow: 20 bytes arrive while the parser is stuck in a response
      send_ready = 1'b0;
      rdValue    = 8'h00;
      sendCmd("r00", 8'h0A);
      waitValid("ovf_valid");
      cmd = "w0101";
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < cmd.len(); i++) applyStimulus(cmd[i]);
         applyStimulus(8'h0D);
      end
      applyStimulus(8'h77);
      applyStimulus(8'h30);
      idleInput();
      checkOutput("ovf_set", {31'h0, ovf}, 32'd1);
      checkOutput("ovf_pre_wr", wrCount, 1);
      send_ready = 1'b1;
      expectBytes("ovf_rd", 32'h30300D0A, 4);
      expectBytes("ovf_err1", 32'h00450D0A, 3);
      checkOutput("ovf_cleared", {31'h0, ovf}, 32'd0);
      checkOutput("ovf_err1_wr", wrCount, 1);
      expectBytes("ovf_wr2", 32'h004B0D0A, 3);
      checkOutput("ovf_wr2_count", wrCount, 2);
      checkOutput("ovf_wr2_addr", {24'h0, lastWrAddr}, 32'h01);
      checkOutput("ovf_wr2_data", {24'h0, lastWrData}, 32'h01);
      expectQuiet("ovf_partial_quiet", 20);
      sendCmd("", 8'h0D);
      expectBytes("ovf_err3", 32'h00450D0A, 3);
      checkOutput("ovf_final_wr", wrCount, 2);
      checkOutput("ovf_final_rd", rdCount, 3);
      checkOutput("ovf_final_flag", {31'h0, ovf}, 32'd0);

      // Reset in the middle of a response
      send_ready = 1'b0;
      rdValue    = 8'h11;
      sendCmd("r7e", 8'h0A);
      waitValid("rst_valid");
      checkOutput("rst_pre_addr", {24'h0, reg_addr}, 32'h7E);
      #1 rstn = 1'b0;
      #1;
      checkOutput("rst_outputs",
                  {4'h0, send_valid, reg_wr, reg_rd, ovf, send_data, reg_addr, reg_wdata},
                  32'h0);
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      rxQ.delete();
      send_ready = 1'b1;
      expectQuiet("rst_no_stale", 10);
      rdBefore = rdCount;
      rdValue  = 8'h9C;
      sendCmd("r01", 8'h0A);
      expectBytes("rst_rd", 32'h39430D0A, 4);
      checkOutput("rst_rd_count", rdCount - rdBefore, 1);
      checkOutput("rst_rd_addr", {24'h0, lastRdAddr}, 32'h01);
      expectQuiet("rst_end_quiet", 20);
      checkOutput("never_both", bothCount, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
